// File: rtl/pipe_seq_ctrl_if.sv
// Debug-command and pipeline-control bundle for pipe_seq_ctrl.
// master drives commands and the ID-stage halt decode; slave is the controller.
interface pipe_seq_ctrl_if;
    logic        i_cmd_valid;
    logic [1:0]  i_cmd;
    logic        i_halt_detected;
    logic        o_cmd_ready;
    logic        o_fetch_enable;
    logic        o_pipe_enable;
    logic        o_flush_all;
    logic        o_step_done;
    logic        o_cmd_err;
    logic        o_halted;
    logic [2:0]  o_state;
    logic [31:0] o_cycle_count;

    modport master (
        output i_cmd_valid, i_cmd, i_halt_detected,
        input  o_cmd_ready, o_fetch_enable, o_pipe_enable, o_flush_all,
               o_step_done, o_cmd_err, o_halted, o_state, o_cycle_count
    );

    modport slave (
        input  i_cmd_valid, i_cmd, i_halt_detected,
        output o_cmd_ready, o_fetch_enable, o_pipe_enable, o_flush_all,
               o_step_done, o_cmd_err, o_halted, o_state, o_cycle_count
    );
endinterface

// File: rtl/pipe_seq_ctrl.sv
// Debug run/step/halt/flush sequencer for a 5-stage pipeline.
// Enables are Moore decodes of the registered state; step_done/cmd_err are registered pulses.
module pipe_seq_ctrl (
    input  logic           i_clk,
    input  logic           i_reset,
    pipe_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4,
        ST_FLUSH  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CMD_RUN   = 2'b00,
        CMD_STEP  = 2'b01,
        CMD_HALT  = 2'b10,
        CMD_FLUSH = 2'b11
    } cmd_t;

    state_t      state;
    logic [2:0]  drain_cnt;
    logic        flush_cnt;
    logic [31:0] cycle_cnt;
    logic        step_done_q;
    logic        cmd_err_q;
    logic        cmd_ready;
    logic        pipe_en;
    logic        accept;
    cmd_t        cmd;

    always_comb begin
        cmd       = cmd_t'(bus.i_cmd);
        cmd_ready = (state == ST_IDLE) || (state == ST_RUN) || (state == ST_HALTED);
        pipe_en   = (state == ST_RUN) || (state == ST_STEP) || (state == ST_DRAIN);
        accept    = bus.i_cmd_valid && cmd_ready;
    end

    always_comb begin
        bus.o_cmd_ready    = cmd_ready;
        bus.o_fetch_enable = (state == ST_RUN) || (state == ST_STEP);
        bus.o_pipe_enable  = pipe_en;
        bus.o_flush_all    = (state == ST_FLUSH);
        bus.o_halted       = (state == ST_HALTED);
        bus.o_state        = state;
        bus.o_cycle_count  = cycle_cnt;
        bus.o_step_done    = step_done_q;
        bus.o_cmd_err      = cmd_err_q;
    end

    // Later assignments in the case override the saturating increment (FLUSH entry clears it).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            drain_cnt   <= '0;
            flush_cnt   <= 1'b0;
            cycle_cnt   <= '0;
            step_done_q <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            step_done_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            if (pipe_en && (cycle_cnt != '1))
                cycle_cnt <= cycle_cnt + 32'd1;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (cmd)
                            CMD_RUN:  state <= ST_RUN;
                            CMD_STEP: state <= ST_STEP;
                            CMD_FLUSH: begin
                                state     <= ST_FLUSH;
                                flush_cnt <= 1'b1;
                                cycle_cnt <= '0;
                            end
                            default:  cmd_err_q <= 1'b1;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (accept && (cmd == CMD_FLUSH)) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= 1'b1;
                        cycle_cnt <= '0;
                    end else if (bus.i_halt_detected || (accept && (cmd == CMD_HALT))) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= 3'd3;
                    end
                    if (accept && ((cmd == CMD_RUN) || (cmd == CMD_STEP)))
                        cmd_err_q <= 1'b1;
                end
                ST_STEP: begin
                    if (bus.i_halt_detected) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= 3'd3;
                    end else begin
                        state       <= ST_IDLE;
                        step_done_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == 3'd0)
                        state <= ST_HALTED;
                    else
                        drain_cnt <= drain_cnt - 3'd1;
                end
                ST_HALTED: begin
                    if (accept) begin
                        if (cmd == CMD_FLUSH) begin
                            state     <= ST_FLUSH;
                            flush_cnt <= 1'b1;
                            cycle_cnt <= '0;
                        end else begin
                            cmd_err_q <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == 1'b0)
                        state <= ST_IDLE;
                    else
                        flush_cnt <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/pipe_seq_ctrl.md
PIPE_SEQ_CTRL -- requirements
Module: pipe_seq_ctrl

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL expose: i_clk  input  1  rising-edge clock.
REQ-003 SHALL expose: i_reset  input  1  synchronous active-high reset.
REQ-004 SHALL expose: i_cmd_valid  input  1  debug command present.
REQ-005 SHALL expose: i_cmd  input  2  command; 00 RUN, 01 STEP, 10 HALT, 11 FLUSH.
REQ-006 SHALL expose: i_halt_detected  input  1  HALT opcode decoded in ID this cycle.
REQ-007 SHALL expose: o_cmd_ready  output  1  command accepted this cycle when high with i_cmd_valid.
REQ-008 SHALL expose: o_fetch_enable  output  1  PC/IF-ID register update enable.
REQ-009 SHALL expose: o_pipe_enable  output  1  ID-EX, EX-M, M-WB register update enable.
REQ-010 SHALL expose: o_flush_all  output  1  clear all pipeline registers.
REQ-011 SHALL expose: o_step_done  output  1  single-cycle pulse on step completion.
REQ-012 SHALL expose: o_cmd_err  output  1  single-cycle pulse on discarded command.
REQ-013 SHALL expose: o_halted  output  1  high while in HALTED.
REQ-014 SHALL expose: o_state  output  3  current state encoding.
REQ-015 SHALL expose: o_cycle_count  output  32  count of cycles with o_pipe_enable high.

Function
REQ-016 SHALL implement states IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4, FLUSH=5; codes 6-7 SHALL transition to IDLE next cycle.
REQ-017 SHALL drive o_fetch_enable=1 only in RUN/STEP; o_pipe_enable=1 only in RUN/STEP/DRAIN; o_flush_all=1 only in FLUSH; o_halted=1 only in HALTED (all Moore, decoded from registered state).
REQ-018 SHALL drive o_cmd_ready=1 in IDLE, RUN, HALTED; 0 in STEP, DRAIN, FLUSH.
REQ-019 Command accepted in cycle N SHALL take effect as state in cycle N+1 (one-cycle latency).
REQ-020 IDLE: RUN->RUN; STEP->STEP; FLUSH->FLUSH; HALT->accepted, no state change, o_cmd_err pulse next cycle.
REQ-021 RUN: HALT cmd or i_halt_detected->DRAIN; FLUSH cmd->FLUSH; RUN/STEP cmd accepted, discarded, o_cmd_err pulse.
REQ-022 RUN with FLUSH cmd and i_halt_detected same cycle SHALL go to FLUSH (FLUSH priority).
REQ-023 RUN with HALT cmd and i_halt_detected same cycle SHALL enter DRAIN once, no o_cmd_err.
REQ-024 STEP SHALL last exactly one cycle; next state DRAIN if i_halt_detected, else IDLE; o_step_done SHALL pulse the cycle after STEP exits to IDLE.
REQ-025 DRAIN SHALL last exactly 4 cycles (3-bit down-counter loaded with 3 on entry), then HALTED; i_halt_detected ignored in DRAIN.
REQ-026 HALTED: FLUSH->FLUSH; RUN/STEP/HALT accepted, discarded, o_cmd_err pulse.
REQ-027 FLUSH SHALL last exactly 2 cycles, then IDLE.
REQ-028 o_cycle_count SHALL increment by 1 on each edge where o_pipe_enable=1, saturate at 0xFFFFFFFF, and clear on entry to FLUSH.
REQ-029 o_step_done and o_cmd_err SHALL be registered, never high two consecutive cycles from one event.

Reset
REQ-030 i_reset high at a rising edge SHALL force state IDLE, clear drain/flush counters and o_cycle_count, and drive o_step_done=0, o_cmd_err=0, o_fetch_enable=0, o_pipe_enable=0, o_flush_all=0, o_halted=0, o_cmd_ready=1 from the next cycle.
REQ-031 Reset SHALL take priority over any command or i_halt_detected in the same cycle, including mid-DRAIN and mid-FLUSH.

Verification
REQ-032 Reset, RUN cmd, 10 cycles, i_halt_detected pulse -> fetch_enable drops next cycle, pipe_enable high 4 more cycles, o_halted=1, o_cycle_count=15.
REQ-033 From IDLE, three STEP cmds spaced 3 cycles -> three single-cycle fetch/pipe enables, three o_step_done pulses, o_cycle_count=3.
REQ-034 HALTED, STEP cmd -> o_cmd_err one pulse, state stays 4; then FLUSH -> o_flush_all high 2 cycles, state 0, o_cycle_count=0.
REQ-035 RUN with FLUSH cmd and i_halt_detected same cycle -> state FLUSH, no DRAIN.
REQ-036 i_reset asserted in 2nd DRAIN cycle -> next cycle state 0, all enables 0, o_cycle_count=0.
REQ-037 o_cycle_count preset near 0xFFFFFFFE via long RUN (or force) -> holds at 0xFFFFFFFF, no wrap.
